// File: rtl/ring_messenger_mc_if.sv
// CPU queue and token-ring signal bundle for ring_messenger_mc.
// master = CPU/ring environment side, slave = the messenger itself.
interface ring_messenger_mc_if #(
  parameter int CORE_W   = 4,
  parameter int LEN_W    = 6,
  parameter int TYPE_W   = 4,
  parameter int MQ_DEPTH = 64
);
  localparam int LVL_W = $clog2(MQ_DEPTH) + 1;

  logic [TYPE_W+LEN_W+CORE_W-1:0] aq;
  logic                           read;
  logic                           selMsgr;
  logic [31:0]                    wq;
  logic                           rwq;
  logic [31:0]                    rq;
  logic                           wrq;
  logic                           done;
  logic [CORE_W-1:0]              whichCore;
  logic [31:0]                    RingIn;
  logic [3:0]                     SlotTypeIn;
  logic [CORE_W-1:0]              SourceIn;
  logic [31:0]                    RingOut;
  logic [3:0]                     SlotTypeOut;
  logic [CORE_W-1:0]              SourceOut;
  logic                           DriveRing;
  logic                           WantsToken;
  logic                           AcquireToken;
  logic                           consume;
  logic                           ctrlValid;
  logic [TYPE_W-1:0]              ctrlType;
  logic [CORE_W-1:0]              ctrlSrc;
  logic [LVL_W-1:0]               mqLevel;
  logic [15:0]                    dropCount;

  modport master (
    output aq, read, selMsgr, wq, whichCore, RingIn, SlotTypeIn, SourceIn, AcquireToken,
    input  rwq, rq, wrq, done, RingOut, SlotTypeOut, SourceOut, DriveRing, WantsToken,
           consume, ctrlValid, ctrlType, ctrlSrc, mqLevel, dropCount
  );

  modport slave (
    input  aq, read, selMsgr, wq, whichCore, RingIn, SlotTypeIn, SourceIn, AcquireToken,
    output rwq, rq, wrq, done, RingOut, SlotTypeOut, SourceOut, DriveRing, WantsToken,
           consume, ctrlValid, ctrlType, ctrlSrc, mqLevel, dropCount
  );
endinterface

// File: rtl/ring_messenger_mc.sv
// Messenger between CPU AQ/WQ/RQ and the token ring; rx messages land in a FWFT MQ with whole-message
// admission. Ring/CPU strobes are same-cycle; the MQ never backpressures the ring (overflow drops).
module ring_messenger_mc #(
  parameter int CORE_W   = 4,
  parameter int LEN_W    = 6,
  parameter int TYPE_W   = 4,
  parameter int MQ_DEPTH = 64,
  parameter int BCAST_EN = 1
) (
  input logic               clock,
  input logic               reset,
  ring_messenger_mc_if.slave bus
);
  localparam int AW    = $clog2(MQ_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [2:0] {IDLE, WAIT_TOKEN, SEND, COPY_HDR, COPY_PAY} state_t;

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  in_len;
  logic              in_keep;
  logic              in_consume;
  logic [31:0]       mem [MQ_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [15:0]       drops;

  logic [LEN_W-1:0]  rx_len;
  logic [TYPE_W-1:0] rx_type;
  logic [CORE_W-1:0] rx_src;
  logic [CORE_W-1:0] rx_dest;
  logic              is_msg, is_hdr, is_pay;
  logic              uni, bcast, mine, sink, admit, drop, push, pop;
  logic [LVL_W:0]    free_words, need_words;
  logic [31:0]       head;
  logic [LEN_W-1:0]  aq_len;
  logic [TYPE_W-1:0] aq_type;
  logic [CORE_W-1:0] aq_dest;

  assign rx_len  = bus.RingIn[LEN_W-1:0];
  assign rx_type = bus.RingIn[LEN_W +: TYPE_W];
  assign rx_src  = bus.RingIn[LEN_W+TYPE_W +: CORE_W];
  assign rx_dest = bus.RingIn[LEN_W+TYPE_W+CORE_W +: CORE_W];

  assign is_msg = (bus.SlotTypeIn == 4'd8);
  assign is_hdr = is_msg && (in_len == '0);
  assign is_pay = is_msg && (in_len != '0);

  // A broadcast is never treated as a unicast, even when dest happens to equal this core.
  assign bcast = (BCAST_EN != 0) && (rx_dest == rx_src);
  assign uni   = (rx_dest == bus.whichCore) && !bcast;
  assign mine  = uni || (bcast && (bus.SourceIn != bus.whichCore));
  assign sink  = uni || (bcast && (bus.SourceIn == bus.whichCore));

  assign free_words = (LVL_W+1)'(MQ_DEPTH) - (LVL_W+1)'(level);
  assign need_words = (LVL_W+1)'(rx_len) + (LVL_W+1)'(1);
  assign admit      = mine && (rx_len != '0) && (free_words >= need_words);
  assign drop       = is_hdr && mine && (rx_len != '0) && !admit;
  assign push       = (is_hdr && admit) || (is_pay && in_keep);

  assign bus.consume   = (is_hdr && sink) || (is_pay && in_consume);
  assign bus.ctrlValid = is_hdr && mine && (rx_len == '0);
  assign bus.ctrlType  = bus.ctrlValid ? rx_type : '0;
  assign bus.ctrlSrc   = bus.ctrlValid ? rx_src : '0;

  assign head = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.RingIn;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_len     <= '0;
      in_keep    <= 1'b0;
      in_consume <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drops      <= '0;
    end else begin
      if (is_hdr) begin
        in_len     <= rx_len;
        in_keep    <= admit;
        in_consume <= sink;
      end else if (is_pay) begin
        in_len <= in_len - LEN_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop && (drops != 16'hFFFF)) drops <= drops + 16'd1;
    end
  end

  assign aq_dest = bus.aq[CORE_W-1:0];
  assign aq_len  = bus.aq[CORE_W +: LEN_W];
  assign aq_type = bus.aq[CORE_W+LEN_W +: TYPE_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.selMsgr && !bus.read) state <= WAIT_TOKEN;
          else if (bus.selMsgr && bus.read && (level != '0)) state <= COPY_HDR;
        end
        WAIT_TOKEN: begin
          if (bus.AcquireToken) begin
            state <= (aq_len == '0) ? IDLE : SEND;
            cnt   <= aq_len;
          end
        end
        SEND: begin
          cnt <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state <= IDLE;
        end
        COPY_HDR: begin
          cnt   <= head[LEN_W-1:0];
          state <= COPY_PAY;
        end
        COPY_PAY: begin
          cnt <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ring and CPU strobes follow the current state and inputs so token-grant and empty-poll act in-cycle.
  always_comb begin
    bus.RingOut    = '0;
    bus.DriveRing  = 1'b0;
    bus.WantsToken = 1'b0;
    bus.rwq        = 1'b0;
    bus.rq         = '0;
    bus.wrq        = 1'b0;
    bus.done       = 1'b0;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        if (bus.selMsgr && bus.read && (level == '0)) begin
          bus.wrq  = 1'b1;
          bus.done = 1'b1;
        end
      end
      WAIT_TOKEN: begin
        bus.WantsToken = 1'b1;
        if (bus.AcquireToken) begin
          bus.DriveRing = 1'b1;
          bus.RingOut   = 32'({aq_dest, bus.whichCore, aq_type, aq_len});
          bus.done      = (aq_len == '0);
        end
      end
      SEND: begin
        bus.DriveRing = 1'b1;
        bus.RingOut   = bus.wq;
        bus.rwq       = 1'b1;
        bus.done      = (cnt == LEN_W'(1));
      end
      COPY_HDR: begin
        bus.rq  = head;
        bus.wrq = 1'b1;
        pop     = 1'b1;
      end
      COPY_PAY: begin
        bus.rq   = head;
        bus.wrq  = 1'b1;
        pop      = 1'b1;
        bus.done = (cnt == LEN_W'(1));
      end
      default: ;
    endcase
  end

  assign bus.SlotTypeOut = 4'd8;
  assign bus.SourceOut   = bus.whichCore;
  assign bus.mqLevel     = level;
  assign bus.dropCount   = drops;
endmodule
